// File: rtl/spi_pkg.sv
// Shared SPI definitions: data width limit, receive read-FSM states and
// the GPMC register map for the receive FIFO.
package spi_pkg;

    localparam int MAX_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } rx_rd_state_t;

    // GPMC byte offsets of the receive-FIFO registers
    localparam logic [7:0] RXF_REG_DATA_HI = 8'h20;
    localparam logic [7:0] RXF_REG_DATA_LO = 8'h22;
    localparam logic [7:0] RXF_REG_STATUS  = 8'h24;
    localparam logic [7:0] RXF_REG_CONTROL = 8'h26;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive-side FIFO between the SPI master core and the GPMC register file.
// Captures each completed SPI word on a rising edge of new_data and returns
// buffered words as a coherent high-half / low-half read pair.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = MAX_DATA_WIDTH,
    parameter int BUS_WIDTH  = 16,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         new_data,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    input  logic                         rd_hi,
    input  logic                         rd_lo,
    input  logic                         clr,
    output logic [BUS_WIDTH-1:0]         rd_data,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic [$clog2(DEPTH):0]       level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] hold;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_nxt;
    logic                  new_data_q;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  drop;
    rx_rd_state_t          state;

    // Push/pop decisions; a full FIFO still accepts a word when a pop frees a slot
    always_comb begin
        head      = mem[rd_ptr];
        push      = new_data & ~new_data_q;
        pop       = rd_hi & (state == IDLE) & ~empty;
        accept    = push & (~full | pop);
        drop      = push & full & ~pop;
        level_nxt = level;
        if (accept && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (!accept && pop) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Rising-edge detector; starts high so a word pending at reset release is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_data_q <= 1'b1;
        end else begin
            new_data_q <= new_data;
        end
    end

    // Word storage, no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (!clr && accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers, level counter and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == LVL_W'(DEPTH));
        end
    end

    // Read FSM: rd_hi pops into hold, rd_lo returns the other half; rd_hi wins if both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hold    <= '0;
            rd_data <= '0;
        end else if (clr) begin
            state   <= IDLE;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_hi) begin
                        if (!empty) begin
                            hold    <= head;
                            rd_data <= head[DATA_WIDTH-1 -: BUS_WIDTH];
                            state   <= HELD;
                        end else begin
                            rd_data <= '0;
                        end
                    end else if (rd_lo) begin
                        rd_data <= '0;
                    end
                end
                HELD: begin
                    if (rd_hi) begin
                        rd_data <= hold[DATA_WIDTH-1 -: BUS_WIDTH];
                    end else if (rd_lo) begin
                        rd_data <= hold[BUS_WIDTH-1:0];
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Self-checking bench for spi_rx_fifo: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_spi_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_data;
    logic [31:0] rx_data;
    logic        rd_hi;
    logic        rd_lo;
    logic        clr;
    logic [15:0] rd_data;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [4:0]  level;

    int n_tests = 0;
    int n_fail  = 0;

    spi_rx_fifo #(.DATA_WIDTH(32), .BUS_WIDTH(16), .DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .new_data (new_data),
        .rx_data  (rx_data),
        .rd_hi    (rd_hi),
        .rd_lo    (rd_lo),
        .clr      (clr),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        nd;
        logic [31:0] rx;
        logic        hi;
        logic        lo;
        logic        c;
        logic [15:0] e_rd;
        logic [4:0]  e_lvl;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [13];

    // reference model state
    logic [31:0] mq[$];
    logic        m_prev;
    logic        m_held;
    logic [31:0] m_hold;
    logic [15:0] m_rd;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] e_rd, input logic [4:0] e_lvl,
                           input logic e_empty, input logic e_full, input logic e_ovf);
        chk({name, ".rd_data"}, 32'(rd_data), 32'(e_rd));
        chk({name, ".level"}, 32'(level), 32'(e_lvl));
        chk({name, ".empty"}, 32'(empty), 32'(e_empty));
        chk({name, ".full"}, 32'(full), 32'(e_full));
        chk({name, ".overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        new_data = 1'b0;
        rd_hi    = 1'b0;
        rd_lo    = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        new_data = 1'b1;
        rx_data  = w;
        tick();
        new_data = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic hi, input logic lo, input logic c);
        rd_hi = hi;
        rd_lo = lo;
        clr   = c;
        tick();
        rd_hi = 1'b0;
        rd_lo = 1'b0;
        clr   = 1'b0;
    endtask

    // One clock of the specification's behaviour, applied to the model
    task automatic model_step(input logic nd, input logic [31:0] rx, input logic hi,
                              input logic lo, input logic c);
        logic rise;
        int   sz0;
        logic popped;
        rise   = nd && !m_prev;
        m_prev = nd;
        if (c) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_rd   = '0;
            m_held = 1'b0;
            return;
        end
        sz0    = mq.size();
        popped = 1'b0;
        if (hi) begin
            if (m_held) begin
                m_rd = m_hold[31:16];
            end else if (sz0 > 0) begin
                m_hold = mq.pop_front();
                m_rd   = m_hold[31:16];
                m_held = 1'b1;
                popped = 1'b1;
            end else begin
                m_rd = '0;
            end
        end else if (lo) begin
            if (m_held) begin
                m_rd   = m_hold[15:0];
                m_held = 1'b0;
            end else begin
                m_rd = '0;
            end
        end
        if (rise) begin
            if (sz0 < 16 || popped) mq.push_back(rx);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        idle_inputs();
        rx_data = '0;

        // reset with new_data already high: release must not push
        new_data = 1'b1;
        rst_n    = 1'b0;
        repeat (2) tick();
        chk_all("reset", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk_all("nd_high_at_release", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        new_data = 1'b0;
        tick();

        // table: basic pair read, empty reads, coherent retry, rd_hi+rd_lo together
        vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'hDEAD, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'hBEEF, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h1234, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h1234, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h5678, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 16'hAAAA, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h5555, 5'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            new_data = vecs[i].nd;
            rx_data  = vecs[i].rx;
            rd_hi    = vecs[i].hi;
            rd_lo    = vecs[i].lo;
            clr      = vecs[i].c;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_lvl,
                    vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf);
        end
        idle_inputs();
        tick();

        // 17 pushes into 16 entries: last word dropped, overflow sticky
        for (int i = 0; i < 17; i++) push_word(32'(i));
        chk_all("overfill", 16'h5555, 5'd16, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            strobe(1'b1, 1'b0, 1'b0);
            chk($sformatf("drain%0d.hi", i), 32'(rd_data), 32'h0);
            strobe(1'b0, 1'b1, 1'b0);
            chk($sformatf("drain%0d.lo", i), 32'(rd_data), 32'(i));
        end
        chk_all("drained", 16'd15, 5'd0, 1'b1, 1'b0, 1'b1);
        strobe(1'b0, 1'b0, 1'b1);
        chk_all("clr_ovf", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);

        // full FIFO: push and rd_hi in the same cycle keeps level and no overflow
        for (int i = 0; i < 16; i++) push_word(32'h1000_0000 + 32'(i));
        new_data = 1'b1;
        rx_data  = 32'hCAFE_F00D;
        rd_hi    = 1'b1;
        tick();
        idle_inputs();
        chk_all("full_push_pop", 16'h1000, 5'd16, 1'b0, 1'b1, 1'b0);
        tick();
        strobe(1'b0, 1'b1, 1'b0);
        chk("full_push_pop.lo", 32'(rd_data), 32'h0000);
        for (int i = 1; i < 16; i++) begin
            strobe(1'b1, 1'b0, 1'b0);
            strobe(1'b0, 1'b1, 1'b0);
        end
        chk("full_push_pop.w15", 32'(rd_data), 32'h000F);
        strobe(1'b1, 1'b0, 1'b0);
        chk("full_push_pop.new_hi", 32'(rd_data), 32'hCAFE);
        strobe(1'b0, 1'b1, 1'b0);
        chk_all("full_push_pop.new_lo", 16'hF00D, 5'd0, 1'b1, 1'b0, 1'b0);

        // clr while HELD with five words left
        for (int i = 0; i < 6; i++) push_word(32'h5000_0000 + 32'(i));
        strobe(1'b1, 1'b0, 1'b0);
        chk_all("held5", 16'h5000, 5'd5, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b1);
        chk_all("clr_held", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 1'b0);
        chk("clr_held.lo", 32'(rd_data), 32'h0);

        // clr overrides a simultaneous push
        new_data = 1'b1;
        rx_data  = 32'h7777_7777;
        clr      = 1'b1;
        tick();
        idle_inputs();
        chk_all("clr_vs_push", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();

        // asynchronous reset mid-cycle clears immediately
        push_word(32'h1111_2222);
        push_word(32'h3333_4444);
        strobe(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        strobe(1'b0, 1'b1, 1'b0);
        chk("async_rst.lo", 32'(rd_data), 32'h0);

        // randomized run against the reference model
        strobe(1'b0, 1'b0, 1'b1);
        mq.delete();
        m_prev = 1'b0;
        m_held = 1'b0;
        m_hold = '0;
        m_rd   = '0;
        m_ovf  = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            new_data = ($urandom_range(0, 2) == 0);
            rx_data  = $urandom;
            rd_hi    = ($urandom_range(0, 5) == 0);
            rd_lo    = ($urandom_range(0, 4) == 0);
            clr      = ($urandom_range(0, 199) == 0);
            model_step(new_data, rx_data, rd_hi, rd_lo, clr);
            tick();
            chk_all($sformatf("rand%0d", cyc), m_rd, 5'(mq.size()),
                    mq.size() == 0, mq.size() == 16, m_ovf);
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
